// File: rtl/magnetron_ctrl_pkg.sv
// Shared definitions for the magnetron cook controller and its consumers.
// Display and beeper blocks import this package so that every block decodes
// the controller's state output with the same encoding.
package magnetron_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COOK  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3
    } mag_state_e;

    // Longest loadable cook time in seconds (99:59).
    localparam int MAX_TIME_DEFAULT = 5999;

endpackage

// File: rtl/magnetron_ctrl_sec_tick.sv
// sec_tick_gen: one-second prescaler for the cook countdown.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : forces the count back to 0 (wins over enable)
//   enable     : counts one step per cycle while high
//   tick       : one-cycle pulse in the last enabled cycle of each
//                TICK_DIV-cycle period (count == TICK_DIV-1)
module sec_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/magnetron_ctrl.sv
// magnetron_ctrl: cook-cycle controller driving the magnetron SR latch.
// Holds the cook time, counts it down once per second while cooking,
// enforces door interlock and stop/pause, and reports progress.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   start, stop : start/resume and pause/cancel requests (levels)
//   door_closed : interlock, 1 = closed
//   time_load   : load time_in (seconds) into time_left, IDLE only
//   mag_set     : latch set, one-cycle pulse on each COOK entry
//   mag_reset   : latch reset, high whenever the state is not COOK
//   time_left   : remaining seconds
//   state       : current state (magnetron_ctrl_pkg::mag_state_e)
//   done        : high while in DONE
// All outputs come straight from flops; they are computed from the next
// state so they line up with the state register cycle for cycle.
module magnetron_ctrl
    import magnetron_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int TIME_W   = 13,
    parameter int MAX_TIME = MAX_TIME_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              door_closed,
    input  logic              time_load,
    input  logic [TIME_W-1:0] time_in,
    output logic              mag_set,
    output logic              mag_reset,
    output logic [TIME_W-1:0] time_left,
    output logic [2:0]        state,
    output logic              done
);

    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);
    localparam logic [TIME_W-1:0] ONE_S = TIME_W'(1);

    mag_state_e        state_q, state_d;
    logic [TIME_W-1:0] time_left_q, time_left_d;
    logic              mag_set_q, mag_set_d;
    logic              mag_reset_q, mag_reset_d;
    logic              done_q, done_d;
    logic              tick;

    // The prescaler is held cleared outside COOK, so every COOK entry
    // starts at count 0 and the first tick lands TICK_DIV cycles later.
    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != ST_COOK),
        .enable (state_q == ST_COOK),
        .tick   (tick)
    );

    always_comb begin
        state_d     = state_q;
        time_left_d = time_left_q;

        case (state_q)
            ST_IDLE: begin
                if (stop) begin
                    time_left_d = '0;
                end else if (start && door_closed && (time_left_q != '0)) begin
                    state_d = ST_COOK;
                end else if (time_load) begin
                    time_left_d = (time_in > MAX_T) ? MAX_T : time_in;
                end
            end

            ST_COOK: begin
                // Expiry beats a simultaneous stop or door opening.
                if (tick && (time_left_q <= ONE_S)) begin
                    time_left_d = '0;
                    state_d     = ST_DONE;
                end else begin
                    if (tick) begin
                        time_left_d = time_left_q - ONE_S;
                    end
                    if (stop || !door_closed) begin
                        state_d = ST_PAUSE;
                    end
                end
            end

            ST_PAUSE: begin
                if (stop) begin
                    time_left_d = '0;
                    state_d     = ST_IDLE;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                end
            end

            ST_DONE: begin
                if (stop || !door_closed || start) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                time_left_d = '0;
            end
        endcase

        mag_set_d   = (state_d == ST_COOK) && (state_q != ST_COOK);
        mag_reset_d = (state_d != ST_COOK);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            time_left_q <= '0;
            mag_set_q   <= 1'b0;
            mag_reset_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_left_q <= time_left_d;
            mag_set_q   <= mag_set_d;
            mag_reset_q <= mag_reset_d;
            done_q      <= done_d;
        end
    end

    assign mag_set   = mag_set_q;
    assign mag_reset = mag_reset_q;
    assign time_left = time_left_q;
    assign state     = state_q;
    assign done      = done_q;

endmodule

// File: tb/tb_magnetron_ctrl.sv
module tb_magnetron_ctrl;

    localparam int TICK_DIV = 4;
    localparam int TIME_W   = 13;
    localparam int MAX_TIME = 5999;

    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic              door_closed;
    logic              time_load;
    logic [TIME_W-1:0] time_in;
    logic              mag_set;
    logic              mag_reset;
    logic [TIME_W-1:0] time_left;
    logic [2:0]        state;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 idle, 1 cooking, 2 paused, 3 done.
    int m_mode;
    int m_secs;
    int m_cook_cycles;   // cycles spent in the current cooking stretch
    bit m_entered;       // cooking began at the latest edge

    magnetron_ctrl #(
        .TICK_DIV (TICK_DIV),
        .TIME_W   (TIME_W),
        .MAX_TIME (MAX_TIME)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .time_load   (time_load),
        .time_in     (time_in),
        .mag_set     (mag_set),
        .mag_reset   (mag_reset),
        .time_left   (time_left),
        .state       (state),
        .done        (done)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("state", 32'(state), 32'(m_mode));
        check("time_left", 32'(time_left), 32'(m_secs));
        check("mag_set", 32'(mag_set), 32'(m_entered));
        check("mag_reset", 32'(mag_reset), 32'(m_mode != 1));
        check("done", 32'(done), 32'(m_mode == 3));
        check("set_reset_exclusive", 32'(mag_set & mag_reset), 32'(0));
    endtask

    task automatic model_reset();
        m_mode        = 0;
        m_secs        = 0;
        m_cook_cycles = 0;
        m_entered     = 0;
    endtask

    // Advances the model by one clock using the currently driven inputs.
    task automatic model_next();
        int  prev;
        bit  second_done;
        prev        = m_mode;
        second_done = (m_mode == 1) && ((m_cook_cycles % TICK_DIV) == TICK_DIV - 1);
        if (rst) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: begin
                if (stop) m_secs = 0;
                else if (start && door_closed && m_secs != 0) m_mode = 1;
                else if (time_load) m_secs = (int'(time_in) > MAX_TIME) ? MAX_TIME : int'(time_in);
            end
            1: begin
                if (second_done && m_secs == 1) begin
                    m_secs = 0;
                    m_mode = 3;
                end else begin
                    if (second_done) m_secs = m_secs - 1;
                    if (stop || !door_closed) m_mode = 2;
                end
            end
            2: begin
                if (stop) begin
                    m_secs = 0;
                    m_mode = 0;
                end else if (start && door_closed) m_mode = 1;
            end
            default: begin
                if (stop || !door_closed || start) m_mode = 0;
            end
        endcase
        m_entered     = (m_mode == 1) && (prev != 1);
        m_cook_cycles = (m_mode == 1 && prev == 1) ? m_cook_cycles + 1 : 0;
    endtask

    // ---------------- driver ----------------
    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic cyc(input bit s, input bit p, input bit d, input bit l, input int t);
        start       = s;
        stop        = p;
        door_closed = d;
        time_load   = l;
        time_in     = TIME_W'(t);
        step();
    endtask

    task automatic idle_cycles(input int n, input bit d);
        for (int i = 0; i < n; i++) cyc(0, 0, d, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        start = 0; stop = 0; door_closed = 1; time_load = 0; time_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Load 3 and cook to completion.
        cyc(0, 0, 1, 1, 3);
        cyc(1, 0, 1, 0, 0);
        idle_cycles(13, 1);
        check("cook3_done", 32'(done), 32'(1));
        cyc(1, 0, 1, 0, 0);

        // Cook 5, open door at 2 seconds left, then resume.
        cyc(0, 0, 1, 1, 5);
        cyc(1, 0, 1, 0, 0);
        idle_cycles(12, 1);
        check("pause_at_2_pre", 32'(time_left), 32'(2));
        cyc(0, 0, 0, 0, 0);
        check("pause_state", 32'(state), 32'(2));
        idle_cycles(3, 0);
        cyc(1, 0, 1, 0, 0);
        idle_cycles(9, 1);
        check("resume_done", 32'(state), 32'(3));
        cyc(0, 1, 1, 0, 0);

        // Start ignored with nothing loaded or with the door open.
        cyc(1, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 5);
        cyc(1, 0, 0, 0, 0);
        check("open_door_start_idle", 32'(state), 32'(0));

        // Saturating load, then stop beats start in PAUSE.
        cyc(0, 0, 1, 1, 7000);
        check("load_saturates", 32'(time_left), 32'(MAX_TIME));
        cyc(1, 0, 1, 0, 0);
        idle_cycles(5, 1);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        check("stop_beats_start", 32'(time_left), 32'(0));

        // Expiry beats a stop on the same cycle, then door opening clears DONE.
        cyc(0, 0, 1, 1, 1);
        cyc(1, 0, 1, 0, 0);
        idle_cycles(TICK_DIV - 1, 1);
        cyc(0, 1, 1, 0, 0);
        check("expiry_wins", 32'(state), 32'(3));
        cyc(0, 0, 0, 0, 0);
        check("door_leaves_done", 32'(done), 32'(0));

        // Reset asserted in the middle of a cook.
        cyc(0, 0, 1, 1, 9);
        cyc(1, 0, 1, 0, 0);
        idle_cycles(6, 1);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        rst = 1'b0;
        idle_cycles(3, 1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 3) == 0),
                ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 11) != 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(5990, 8191))
                                            : int'($urandom_range(0, 6)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
